// File: rtl/exu_disp_mc.sv
// Multi-channel dispatch stage: one registered output slot steered to NCH channels,
// x0 operand masking, and an optional OITF hazard tracker (enabled by EXU_DISP_OITF_EN).
module exu_disp_mc #(
   parameter int XLEN          = 32,
   parameter int PC_SIZE       = 32,
   parameter int RFIDX_WIDTH   = 5,
   parameter int DECINFO_WIDTH = 32,
   parameter int NCH           = 3,
   parameter logic [NCH-1:0] LONGPIPE_MASK = 3'b110,
   parameter int OITF_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          disp_i_valid,
   output logic                          disp_i_ready,
   input  logic [NCH-1:0]                disp_i_chsel,
   input  logic                          disp_i_rs1x0,
   input  logic                          disp_i_rs2x0,
   input  logic                          disp_i_rs1en,
   input  logic                          disp_i_rs2en,
   input  logic [RFIDX_WIDTH-1:0]        disp_i_rs1idx,
   input  logic [RFIDX_WIDTH-1:0]        disp_i_rs2idx,
   input  logic [XLEN-1:0]               disp_i_rs1,
   input  logic [XLEN-1:0]               disp_i_rs2,
   input  logic                          disp_i_rdwen,
   input  logic [RFIDX_WIDTH-1:0]        disp_i_rdidx,
   input  logic [DECINFO_WIDTH-1:0]      disp_i_info,
   input  logic [XLEN-1:0]               disp_i_imm,
   input  logic [PC_SIZE-1:0]            disp_i_pc,
   output logic [NCH-1:0]                disp_o_valid,
   input  logic [NCH-1:0]                disp_o_ready,
   output logic [XLEN-1:0]               disp_o_rs1,
   output logic [XLEN-1:0]               disp_o_rs2,
   output logic [XLEN-1:0]               disp_o_imm,
   output logic                          disp_o_rdwen,
   output logic [RFIDX_WIDTH-1:0]        disp_o_rdidx,
   output logic [DECINFO_WIDTH-1:0]      disp_o_info,
   output logic [PC_SIZE-1:0]            disp_o_pc,
   output logic [$clog2(OITF_DEPTH)-1:0] disp_o_itag,
   input  logic                          oitf_ret_ena,
   output logic                          oitf_empty
);

   localparam int TW = $clog2(OITF_DEPTH);

   logic           slot_vld;
   logic [NCH-1:0] slot_ch;
   logic [TW-1:0]  slot_tag;
   logic           drain;
   logic           slot_free;
   logic           accept;
   logic           hazard;
   logic           need_alloc;
   logic           oitf_full;
   logic [TW-1:0]  alloc_tag;

   assign disp_o_valid = slot_ch & {NCH{slot_vld}};
   assign drain        = |(disp_o_valid & disp_o_ready);
   assign slot_free    = !slot_vld | drain;
   assign disp_i_ready = slot_free & !hazard & !(need_alloc & oitf_full);
   assign accept       = disp_i_valid & disp_i_ready;
   assign disp_o_itag  = slot_vld ? slot_tag : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_vld     <= 1'b0;
         slot_ch      <= '0;
         slot_tag     <= '0;
         disp_o_rs1   <= '0;
         disp_o_rs2   <= '0;
         disp_o_imm   <= '0;
         disp_o_rdwen <= 1'b0;
         disp_o_rdidx <= '0;
         disp_o_info  <= '0;
         disp_o_pc    <= '0;
      end else if (accept) begin
         slot_vld     <= 1'b1;
         slot_ch      <= disp_i_chsel;
         slot_tag     <= need_alloc ? alloc_tag : '0;
         disp_o_rs1   <= disp_i_rs1 & ~{XLEN{disp_i_rs1x0}};
         disp_o_rs2   <= disp_i_rs2 & ~{XLEN{disp_i_rs2x0}};
         disp_o_imm   <= disp_i_imm;
         disp_o_rdwen <= disp_i_rdwen;
         disp_o_rdidx <= disp_i_rdidx;
         disp_o_info  <= disp_i_info;
         disp_o_pc    <= disp_i_pc;
      end else if (drain) begin
         slot_vld     <= 1'b0;
      end
   end

`ifdef EXU_DISP_OITF_EN
   localparam logic [TW:0] FULL_CNT = (TW+1)'(OITF_DEPTH);

   logic [RFIDX_WIDTH-1:0] oitf_rd [OITF_DEPTH];
   logic [OITF_DEPTH-1:0]  oitf_vld;
   logic [TW-1:0]          wptr;
   logic [TW-1:0]          rptr;
   logic [TW:0]            count;
   logic [TW:0]            count_nxt;
   logic                   empty_q;
   logic                   alloc;
   logic                   ret;

   assign need_alloc = disp_i_rdwen & (|(disp_i_chsel & LONGPIPE_MASK)) & (disp_i_rdidx != '0);
   assign oitf_full  = (count == FULL_CNT);
   assign alloc_tag  = wptr;
   assign alloc      = accept & need_alloc;
   assign ret        = oitf_ret_ena & (count != '0);
   assign oitf_empty = empty_q;

   // Retiring entries still block: the hazard sees only registered valid bits.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
         if (oitf_vld[i]) begin
            if ((disp_i_rs1en & !disp_i_rs1x0 & (oitf_rd[i] == disp_i_rs1idx)) |
                (disp_i_rs2en & !disp_i_rs2x0 & (oitf_rd[i] == disp_i_rs2idx)) |
                (disp_i_rdwen & (disp_i_rdidx != '0) & (oitf_rd[i] == disp_i_rdidx)))
               hazard = 1'b1;
         end
      end
   end

   always_comb begin
      count_nxt = count;
      if (alloc & !ret)
         count_nxt = count + 1'b1;
      else if (ret & !alloc)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < OITF_DEPTH; i++)
            oitf_rd[i] <= '0;
         oitf_vld <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         empty_q  <= 1'b1;
      end else begin
         if (alloc) begin
            oitf_rd[wptr]  <= disp_i_rdidx;
            oitf_vld[wptr] <= 1'b1;
            wptr           <= wptr + 1'b1;
         end
         if (ret) begin
            oitf_vld[rptr] <= 1'b0;
            rptr           <= rptr + 1'b1;
         end
         count   <= count_nxt;
         empty_q <= (count_nxt == '0);
      end
   end
`else
   logic unused_oitf;

   assign hazard      = 1'b0;
   assign need_alloc  = 1'b0;
   assign oitf_full   = 1'b0;
   assign alloc_tag   = '0;
   assign oitf_empty  = 1'b1;
   assign unused_oitf = ^{oitf_ret_ena, disp_i_rs1en, disp_i_rs2en, disp_i_rs1idx, disp_i_rs2idx};
`endif

endmodule

// File: tb/tb_exu_disp_mc.sv
// Randomized bench for exu_disp_mc against a queue-based dispatch/OITF reference model.
// Follows EXU_DISP_OITF_EN so the same bench covers both builds.
module tb_exu_disp_mc;

   localparam int NCH   = 3;
   localparam int DEPTH = 4;
   localparam logic [2:0] LP = 3'b110;
`ifdef EXU_DISP_OITF_EN
   localparam bit OITF_EN = 1'b1;
`else
   localparam bit OITF_EN = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  ch;
      logic        rs1x0, rs2x0, rs1en, rs2en;
      logic [4:0]  rs1idx, rs2idx;
      logic        rdwen;
      logic [4:0]  rdidx;
      logic [31:0] rs1, rs2, imm, pc, info;
   } ins_t;

   typedef struct {
      logic [4:0] rd;
      logic [1:0] tag;
   } ent_t;

   logic clk, rst;
   logic disp_i_valid, disp_i_ready;
   logic [2:0] disp_i_chsel;
   logic disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en;
   logic [4:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
   logic [31:0] disp_i_rs1, disp_i_rs2, disp_i_info, disp_i_imm, disp_i_pc;
   logic disp_i_rdwen;
   logic [2:0] disp_o_valid, disp_o_ready;
   logic [31:0] disp_o_rs1, disp_o_rs2, disp_o_imm, disp_o_info, disp_o_pc;
   logic disp_o_rdwen;
   logic [4:0] disp_o_rdidx;
   logic [1:0] disp_o_itag;
   logic oitf_ret_ena, oitf_empty;

   int checks = 0;
   int errors = 0;

   // reference model state
   ent_t oq[$];
   int   next_tag;
   bit   m_vld;
   ins_t m_ins;
   logic [1:0] m_tag;
   bit   exp_rdy, obs_rdy;

   wire [5:0]   obs_ctl = {disp_o_valid, disp_o_itag, oitf_empty};
   wire [165:0] obs_pay = {disp_o_rs1, disp_o_rs2, disp_o_imm, disp_o_pc, disp_o_info, disp_o_rdwen, disp_o_rdidx};

   exu_disp_mc dut (
      .clk(clk), .rst(rst),
      .disp_i_valid(disp_i_valid), .disp_i_ready(disp_i_ready), .disp_i_chsel(disp_i_chsel),
      .disp_i_rs1x0(disp_i_rs1x0), .disp_i_rs2x0(disp_i_rs2x0),
      .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
      .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
      .disp_i_rs1(disp_i_rs1), .disp_i_rs2(disp_i_rs2),
      .disp_i_rdwen(disp_i_rdwen), .disp_i_rdidx(disp_i_rdidx),
      .disp_i_info(disp_i_info), .disp_i_imm(disp_i_imm), .disp_i_pc(disp_i_pc),
      .disp_o_valid(disp_o_valid), .disp_o_ready(disp_o_ready),
      .disp_o_rs1(disp_o_rs1), .disp_o_rs2(disp_o_rs2), .disp_o_imm(disp_o_imm),
      .disp_o_rdwen(disp_o_rdwen), .disp_o_rdidx(disp_o_rdidx),
      .disp_o_info(disp_o_info), .disp_o_pc(disp_o_pc), .disp_o_itag(disp_o_itag),
      .oitf_ret_ena(oitf_ret_ena), .oitf_empty(oitf_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && oitf_ret_ena && oitf_empty) begin
         $display("FAIL ret_when_empty t=%0t got retire with oitf_empty=1, want no retire", $time);
         errors++;
      end
      if (!rst && disp_i_valid && !$onehot(disp_i_chsel)) begin
         $display("FAIL chsel_onehot t=%0t got %b, want one-hot", $time, disp_i_chsel);
         errors++;
      end
   end

   function automatic ins_t mk(logic [2:0] ch, bit rdwen, logic [4:0] rd,
                               bit r1en, logic [4:0] r1, bit r2en, logic [4:0] r2);
      ins_t x;
      x.ch = ch; x.rdwen = rdwen; x.rdidx = rd;
      x.rs1en = r1en; x.rs1idx = r1; x.rs1x0 = (r1 == 5'd0);
      x.rs2en = r2en; x.rs2idx = r2; x.rs2x0 = (r2 == 5'd0);
      x.rs1 = $urandom; x.rs2 = $urandom; x.imm = $urandom; x.pc = $urandom; x.info = $urandom;
      return x;
   endfunction

   function automatic ins_t rnd_ins();
      logic [2:0] ch;
      ch = 3'b001 << $urandom_range(2, 0);
      return mk(ch, bit'($urandom % 2), 5'($urandom % 8), bit'($urandom % 2), 5'($urandom % 8),
                bit'($urandom % 2), 5'($urandom % 8));
   endfunction

   function automatic bit m_need_alloc(ins_t x);
      return OITF_EN && x.rdwen && ((x.ch & LP) != 3'b000) && (x.rdidx != 5'd0);
   endfunction

   function automatic bit m_hazard(ins_t x);
      foreach (oq[i]) begin
         if (x.rs1en && !x.rs1x0 && oq[i].rd == x.rs1idx) return 1'b1;
         if (x.rs2en && !x.rs2x0 && oq[i].rd == x.rs2idx) return 1'b1;
         if (x.rdwen && x.rdidx != 5'd0 && oq[i].rd == x.rdidx) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit m_ready(ins_t x, logic [2:0] ordy);
      bit free;
      free = !m_vld || ((m_ins.ch & ordy) != 3'b000);
      return free && !m_hazard(x) && !(m_need_alloc(x) && oq.size() == DEPTH);
   endfunction

   function automatic logic [5:0] exp_ctl();
      return {m_vld ? m_ins.ch : 3'b000, m_vld ? m_tag : 2'b00, oq.size() == 0};
   endfunction

   function automatic logic [165:0] exp_pay();
      return {m_ins.rs1, m_ins.rs2, m_ins.imm, m_ins.pc, m_ins.info, m_ins.rdwen, m_ins.rdidx};
   endfunction

   function automatic void m_clear();
      oq.delete();
      next_tag = 0;
      m_vld = 1'b0;
      m_tag = 2'b00;
   endfunction

   // One clock: drive at edge+1, capture ready, advance the model across the edge, end at edge+1.
   task automatic cyc(input bit v, input ins_t x, input logic [2:0] ordy, input bit ret);
      bit acc;
      ent_t e;
      disp_i_valid = v; disp_i_chsel = x.ch;
      disp_i_rs1x0 = x.rs1x0; disp_i_rs2x0 = x.rs2x0; disp_i_rs1en = x.rs1en; disp_i_rs2en = x.rs2en;
      disp_i_rs1idx = x.rs1idx; disp_i_rs2idx = x.rs2idx; disp_i_rs1 = x.rs1; disp_i_rs2 = x.rs2;
      disp_i_rdwen = x.rdwen; disp_i_rdidx = x.rdidx; disp_i_info = x.info; disp_i_imm = x.imm;
      disp_i_pc = x.pc; disp_o_ready = ordy; oitf_ret_ena = ret;
      #1;
      exp_rdy = m_ready(x, ordy);
      obs_rdy = disp_i_ready;
      acc = v && exp_rdy;
      @(posedge clk);
      if (m_vld && ((m_ins.ch & ordy) != 3'b000)) m_vld = 1'b0;
      if (ret && oq.size() > 0) void'(oq.pop_front());
      if (acc) begin
         m_vld = 1'b1;
         m_ins = x;
         if (x.rs1x0) m_ins.rs1 = 32'd0;
         if (x.rs2x0) m_ins.rs2 = 32'd0;
         if (m_need_alloc(x)) begin
            m_tag = 2'(next_tag);
            e.rd = x.rdidx; e.tag = 2'(next_tag);
            oq.push_back(e);
            next_tag = (next_tag + 1) % DEPTH;
         end else begin
            m_tag = 2'b00;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ins_t z;
      z = '0;
      rst = 1'b1;
      disp_i_valid = 1'b0; disp_i_chsel = z.ch; disp_i_rs1x0 = 0; disp_i_rs2x0 = 0;
      disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs1idx = 0; disp_i_rs2idx = 0;
      disp_i_rs1 = 0; disp_i_rs2 = 0; disp_i_rdwen = 0; disp_i_rdidx = 0;
      disp_i_info = 0; disp_i_imm = 0; disp_i_pc = 0; disp_o_ready = 0; oitf_ret_ena = 0;
      m_clear();
      #3;
      checks++;
      if (obs_ctl !== 6'b000001) begin
         $display("FAIL reset_ctl got %h want %h", obs_ctl, 6'b000001); errors++;
      end
      checks++;
      if (obs_pay !== 166'd0) begin
         $display("FAIL reset_payload got %h want 0", obs_pay); errors++;
      end
      checks++;
      if (disp_i_ready !== 1'b1) begin
         $display("FAIL reset_ready got %b want 1", disp_i_ready); errors++;
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      ins_t x;
      for (int i = 0; i < 9; i++) begin
         x = mk(3'b001, 1'b1, 5'(i + 1), 1'b1, 5'd3, 1'b1, 5'd4);
         if (i % 2 == 0) begin
            x.rs1x0 = 1'b1; x.rs1idx = 5'd0; x.rs1 = 32'hDEADBEEF;
         end
         cyc(i < 8, x, 3'b111, 1'b0);
         checks++;
         if (obs_rdy !== exp_rdy) begin
            $display("FAIL stream_ready t=%0t got %b want %b", $time, obs_rdy, exp_rdy); errors++;
         end
         checks++;
         if (obs_ctl !== exp_ctl()) begin
            $display("FAIL stream_ctl t=%0t got %h want %h", $time, obs_ctl, exp_ctl()); errors++;
         end
         if (m_vld) begin
            checks++;
            if (obs_pay !== exp_pay()) begin
               $display("FAIL stream_payload t=%0t got %h want %h", $time, obs_pay, exp_pay()); errors++;
            end
         end
      end
   endtask

   task automatic test_backpressure();
      ins_t a, b;
      logic [2:0] ordy;
      a = mk(3'b100, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 5'd0);
      b = mk(3'b001, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0);
      for (int i = 0; i < 6; i++) begin
         ordy = (i >= 1 && i <= 3) ? 3'b011 : 3'b111;
         cyc(i < 5, (i == 0) ? a : b, ordy, 1'b0);
         checks++;
         if (obs_rdy !== exp_rdy) begin
            $display("FAIL bp_ready t=%0t got %b want %b", $time, obs_rdy, exp_rdy); errors++;
         end
         checks++;
         if (obs_ctl !== exp_ctl()) begin
            $display("FAIL bp_ctl t=%0t got %h want %h", $time, obs_ctl, exp_ctl()); errors++;
         end
         if (m_vld) begin
            checks++;
            if (obs_pay !== exp_pay()) begin
               $display("FAIL bp_payload t=%0t got %h want %h", $time, obs_pay, exp_pay()); errors++;
            end
         end
      end
   endtask

   task automatic test_raw();
      ins_t a, b;
      int k;
      a = mk(3'b010, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
      b = mk(3'b001, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
      cyc(1'b1, a, 3'b111, 1'b0);
      k = -1;
      for (int i = 0; i < 10 && k < 0; i++) begin
         cyc(1'b1, b, 3'b111, (i == 3) && (oq.size() > 0));
         if (obs_rdy) k = i;
         checks++;
         if (obs_rdy !== exp_rdy) begin
            $display("FAIL raw_ready t=%0t got %b want %b", $time, obs_rdy, exp_rdy); errors++;
         end
         checks++;
         if (obs_ctl !== exp_ctl()) begin
            $display("FAIL raw_ctl t=%0t got %h want %h", $time, obs_ctl, exp_ctl()); errors++;
         end
      end
      checks++;
      if (k !== (OITF_EN ? 4 : 0)) begin
         $display("FAIL raw_accept_cycle got %0d want %0d", k, OITF_EN ? 4 : 0); errors++;
      end
      cyc(1'b0, b, 3'b111, 1'b0);
   endtask

   task automatic test_full_wrap();
      ins_t f, z;
      do_reset();
      f = mk(3'b010, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
      z = mk(3'b001, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      for (int i = 0; i < 9; i++) begin
         case (i)
            0, 1, 2, 3: cyc(1'b1, mk(3'b100, 1'b1, 5'(i + 1), 1'b0, 5'd0, 1'b0, 5'd0), 3'b111, 1'b0);
            4:          cyc(1'b1, f, 3'b111, 1'b0);
            5:          cyc(1'b1, z, 3'b111, 1'b0);
            6:          cyc(1'b1, f, 3'b111, oq.size() > 0);
            7:          cyc(1'b1, f, 3'b111, 1'b0);
            default:    cyc(1'b0, f, 3'b111, 1'b0);
         endcase
         checks++;
         if (obs_rdy !== exp_rdy) begin
            $display("FAIL full_ready step=%0d got %b want %b", i, obs_rdy, exp_rdy); errors++;
         end
         checks++;
         if (obs_ctl !== exp_ctl()) begin
            $display("FAIL full_ctl step=%0d got %h want %h", i, obs_ctl, exp_ctl()); errors++;
         end
      end
   endtask

   task automatic test_alloc_retire();
      ins_t x;
      for (int i = 0; i < 8; i++) begin
         x = mk(3'b100, 1'b1, 5'(20 + i), 1'b0, 5'd0, 1'b0, 5'd0);
         cyc(i == 2 || i == 3, x, 3'b111, (i != 3 || oq.size() == 2) && oq.size() > 0);
         checks++;
         if (obs_rdy !== exp_rdy) begin
            $display("FAIL alloc_ret_ready step=%0d got %b want %b", i, obs_rdy, exp_rdy); errors++;
         end
         checks++;
         if (obs_ctl !== exp_ctl()) begin
            $display("FAIL alloc_ret_ctl step=%0d got %h want %h", i, obs_ctl, exp_ctl()); errors++;
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cyc(bit'($urandom % 4 != 0), rnd_ins(), 3'($urandom), (oq.size() > 0) && ($urandom % 3 == 0));
         checks++;
         if (obs_rdy !== exp_rdy) begin
            $display("FAIL rand_ready i=%0d got %b want %b", i, obs_rdy, exp_rdy); errors++;
         end
         checks++;
         if (obs_ctl !== exp_ctl()) begin
            $display("FAIL rand_ctl i=%0d got %h want %h", i, obs_ctl, exp_ctl()); errors++;
         end
         if (m_vld) begin
            checks++;
            if (obs_pay !== exp_pay()) begin
               $display("FAIL rand_payload i=%0d got %h want %h", i, obs_pay, exp_pay()); errors++;
            end
         end
      end
      for (int i = 0; i < 2 * DEPTH + 2; i++)
         cyc(1'b0, rnd_ins(), 3'b111, oq.size() > 0);
      checks++;
      if (obs_ctl !== exp_ctl()) begin
         $display("FAIL rand_drain got %h want %h", obs_ctl, exp_ctl()); errors++;
      end
   endtask

   task automatic test_reset_midstream();
      cyc(1'b1, mk(3'b100, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0), 3'b111, 1'b0);
      cyc(1'b1, mk(3'b100, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0), 3'b111, 1'b0);
      cyc(1'b1, mk(3'b010, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0), 3'b101, 1'b0);
      cyc(1'b0, mk(3'b010, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0), 3'b101, 1'b0);
      checks++;
      if (obs_ctl !== exp_ctl()) begin
         $display("FAIL mid_pre_ctl got %h want %h", obs_ctl, exp_ctl()); errors++;
      end
      #2;
      rst = 1'b1;
      m_clear();
      #1;
      checks++;
      if (obs_ctl !== 6'b000001) begin
         $display("FAIL mid_reset_ctl got %h want %h", obs_ctl, 6'b000001); errors++;
      end
      checks++;
      if (disp_i_ready !== 1'b1) begin
         $display("FAIL mid_reset_ready got %b want 1", disp_i_ready); errors++;
      end
      checks++;
      if (obs_pay !== 166'd0) begin
         $display("FAIL mid_reset_payload got %h want 0", obs_pay); errors++;
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b1, mk(3'b001, 1'b1, 5'd3, 1'b1, 5'd9, 1'b0, 5'd0), 3'b111, 1'b0);
      checks++;
      if (obs_rdy !== exp_rdy) begin
         $display("FAIL mid_post_ready got %b want %b", obs_rdy, exp_rdy); errors++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_raw();
      test_full_wrap();
      test_alloc_retire();
      test_random();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t got no finish, want finish", $time);
      $fatal(1, "timeout");
   end

endmodule
